// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles a 32-bit little-endian instruction from
// four byte transfers on the unified memory port and hands it to IF/ID.
module if_fetch #(
    parameter logic [31:0] NOP_INST       = 32'h00000013,
    parameter int          BYTES_PER_INST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        mem_ready_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        stallreq_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_INST - 1);

    logic [1:0]  state;
    logic [1:0]  byte_idx;
    logic [31:0] fetch_pc;
    logic [23:0] buffer;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        inst_valid_q;

    logic last_accept;

    assign last_accept  = (state == FETCH) && (byte_idx == LAST_IDX) && mem_ready_i;
    assign mem_req_o    = (state == FETCH);
    assign mem_addr_o   = fetch_pc + {30'd0, byte_idx};
    // Releasing the stall on the final accept lets the PC advance in the same cycle.
    assign stallreq_o   = (state == FETCH) && !last_accept;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = inst_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            byte_idx     <= 2'd0;
            fetch_pc     <= 32'd0;
            buffer       <= 24'd0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= 32'd0;
            inst_valid_q <= 1'b0;
        end else if (flush_i) begin
            state        <= IDLE;
            byte_idx     <= 2'd0;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fetch_pc <= pc_i;
                    byte_idx <= 2'd0;
                    state    <= FETCH;
                end
                FETCH: begin
                    if (mem_ready_i) begin
                        if (byte_idx == LAST_IDX) begin
                            inst_q       <= {mem_rdata_i, buffer};
                            inst_pc_q    <= fetch_pc;
                            inst_valid_q <= 1'b1;
                            byte_idx     <= 2'd0;
                            state        <= DONE;
                        end else begin
                            case (byte_idx)
                                2'd0:    buffer[7:0]   <= mem_rdata_i;
                                2'd1:    buffer[15:8]  <= mem_rdata_i;
                                default: buffer[23:16] <= mem_rdata_i;
                            endcase
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                DONE: begin
                    // The instruction is consumed on this edge; chain straight into the next fetch.
                    if (!stall_i) begin
                        fetch_pc     <= pc_i;
                        byte_idx     <= 2'd0;
                        inst_q       <= NOP_INST;
                        inst_valid_q <= 1'b0;
                        state        <= FETCH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    byte_idx <= 2'd0;
                end
            endcase
        end
    end

endmodule
